// File: rtl/pwm_timer_bank.sv
// pwm_timer_bank: N-channel PWM bank on a shared prescaler.
// Period, hold and phase are double-buffered and swap in at the wrap.
module pwm_timer_bank #(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 16,
  parameter int PRESCALE_TICKS = 600,
  parameter int DEF_PERIOD     = 40000,
  parameter int DEF_HOLD       = 6000,
  parameter bit DEF_PHASE      = 1'b1,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [CNT_W-1:0]    wr_period,
  input  logic [CNT_W-1:0]    wr_hold,
  input  logic                wr_phase,
  input  logic [CHANNELS-1:0] ch_enable,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] period_done,
  output logic                tick
);

  localparam int PRE_W = $clog2(PRESCALE_TICKS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_TICKS - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [CNT_W-1:0] D_PER    = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] D_HLD    = CNT_W'(DEF_HOLD);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [PRE_W-1:0] pre;
  logic             adv;

  assign adv = (pre == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      pre  <= adv ? '0 : pre + PRE_ONE;
      tick <= adv;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] a_per;
    logic [CNT_W-1:0] a_hld;
    logic [CNT_W-1:0] p_per;
    logic [CNT_W-1:0] p_hld;
    logic             a_ph;
    logic             p_ph;
    logic             pwm_q;
    logic             done_q;
    logic             hit;
    logic             run;
    logic             wrap;
    logic             load;

    assign hit  = wr_en && (wr_ch == CH_W'(g));
    assign run  = ch_enable[g] && (a_per != '0);
    assign wrap = adv && run && (cnt == a_per - ONE);
    // a disabled channel tracks its pending set every cycle
    assign load = wrap || !ch_enable[g];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt    <= '0;
        a_per  <= D_PER;
        a_hld  <= D_HLD;
        a_ph   <= DEF_PHASE;
        p_per  <= D_PER;
        p_hld  <= D_HLD;
        p_ph   <= DEF_PHASE;
        pwm_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        if (hit) begin
          p_per <= wr_period;
          p_hld <= wr_hold;
          p_ph  <= wr_phase;
        end
        if (load) begin
          a_per <= hit ? wr_period : p_per;
          a_hld <= hit ? wr_hold   : p_hld;
          a_ph  <= hit ? wr_phase  : p_ph;
        end
        if (!ch_enable[g])
          cnt <= '0;
        else if (adv && (a_per != '0))
          cnt <= wrap ? '0 : cnt + ONE;
        if (run && (cnt < a_hld))
          pwm_q <= a_ph;
        else
          pwm_q <= ~a_ph;
        done_q <= wrap;
      end
    end

    assign pwm_out[g]     = pwm_q;
    assign period_done[g] = done_q;
  end

endmodule

// File: tb/tb_pwm_timer_bank.sv
// tb_pwm_timer_bank: vector table plus scoreboard queue,
// with hand-written async reset sequences.
module tb_pwm_timer_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_period = '0;
  logic [7:0] wr_hold = '0;
  logic       wr_phase = 1'b0;
  logic [3:0] ch_enable = '0;
  logic [3:0] pwm_out;
  logic [3:0] period_done;
  logic       tick;

  pwm_timer_bank #(
    .CHANNELS(4), .CNT_W(8), .PRESCALE_TICKS(4),
    .DEF_PERIOD(5), .DEF_HOLD(2), .DEF_PHASE(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_period(wr_period), .wr_hold(wr_hold), .wr_phase(wr_phase),
    .ch_enable(ch_enable),
    .pwm_out(pwm_out), .period_done(period_done), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic [3:0] en;
    logic       we;
    logic [1:0] ch;
    logic [7:0] per;
    logic [7:0] hld;
    logic       ph;
    logic [3:0] pwm;
    logic [3:0] done;
    logic       tk;
  } vec_t;

  typedef struct {
    int         e;
    logic [3:0] pwm;
    logic [3:0] done;
    logic       tk;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   n;
  int   tests;
  int   fails;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic ck(input int e, input logic [3:0] en, pwm, done, input logic tk);
    vq.push_back('{e, en, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, pwm, done, tk});
  endtask

  task automatic wr(input int e, input logic [3:0] en, input logic [1:0] ch,
                    input logic [7:0] per, hld, input logic ph,
                    input logic [3:0] pwm, done, input logic tk);
    vq.push_back('{e, en, 1'b1, ch, per, hld, ph, pwm, done, tk});
  endtask

  task automatic apply(input vec_t v);
    exp_t x;
    ch_enable = v.en;
    while (n < v.e - 1) step();
    wr_en = v.we;
    wr_ch = v.ch;
    wr_period = v.per;
    wr_hold = v.hld;
    wr_phase = v.ph;
    sb.push_back('{v.e, v.pwm, v.done, v.tk});
    step();
    wr_en = 1'b0;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL e%0d scoreboard: got empty queue, expected entry", v.e);
    end else begin
      x = sb.pop_front();
      chk($sformatf("e%0d pwm_out", x.e), 32'(pwm_out), 32'(x.pwm));
      chk($sformatf("e%0d period_done", x.e), 32'(period_done), 32'(x.done));
      chk($sformatf("e%0d tick", x.e), 32'(tick), 32'(x.tk));
    end
  endtask

  task automatic hit_reset(input string nm);
    #3 reset = 1'b1;
    #1;
    chk({nm, " pwm_out"}, 32'(pwm_out), 32'd0);
    chk({nm, " period_done"}, 32'(period_done), 32'd0);
    chk({nm, " tick"}, 32'(tick), 32'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    ch_enable = 4'b0001;
    reset = 1'b0;
    n = 0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    n = 0;

    // basic run on defaults
    ck(1,   4'b0001, 4'b0001, 4'b0000, 1'b0);
    ck(4,   4'b0001, 4'b0001, 4'b0000, 1'b1);
    ck(5,   4'b0001, 4'b0001, 4'b0000, 1'b0);
    ck(8,   4'b0001, 4'b0001, 4'b0000, 1'b1);
    ck(9,   4'b0001, 4'b0000, 4'b0000, 1'b0);
    ck(16,  4'b0001, 4'b0000, 4'b0000, 1'b1);
    ck(20,  4'b0001, 4'b0000, 4'b0001, 1'b1);
    ck(21,  4'b0001, 4'b0001, 4'b0000, 1'b0);
    ck(28,  4'b0001, 4'b0001, 4'b0000, 1'b1);
    ck(29,  4'b0001, 4'b0000, 4'b0000, 1'b0);
    ck(40,  4'b0001, 4'b0000, 4'b0001, 1'b1);
    ck(41,  4'b0001, 4'b0001, 4'b0000, 1'b0);
    // mid-period write on ch0, takes effect after the wrap at e60
    wr(50,  4'b0001, 2'd0, 8'd3, 8'd1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    ck(60,  4'b0001, 4'b0000, 4'b0001, 1'b1);
    ck(61,  4'b0001, 4'b0000, 4'b0000, 1'b0);
    ck(64,  4'b0001, 4'b0000, 4'b0000, 1'b1);
    ck(65,  4'b0001, 4'b0001, 4'b0000, 1'b0);
    ck(69,  4'b0001, 4'b0001, 4'b0000, 1'b0);
    ck(72,  4'b0001, 4'b0001, 4'b0001, 1'b1);
    ck(73,  4'b0001, 4'b0000, 4'b0000, 1'b0);
    // ch1 written while disabled, then enabled
    wr(74,  4'b0001, 2'd1, 8'd2, 8'd1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    ck(76,  4'b0001, 4'b0010, 4'b0000, 1'b1);
    ck(78,  4'b0011, 4'b0001, 4'b0000, 1'b0);
    ck(80,  4'b0011, 4'b0001, 4'b0000, 1'b1);
    ck(81,  4'b0011, 4'b0011, 4'b0000, 1'b0);
    ck(84,  4'b0011, 4'b0011, 4'b0011, 1'b1);
    ck(85,  4'b0011, 4'b0000, 4'b0000, 1'b0);
    // ch2: hold 0, then hold >= period, then period 0
    wr(86,  4'b0011, 2'd2, 8'd5, 8'd0, 1'b1, 4'b0000, 4'b0000, 1'b0);
    ck(87,  4'b0011, 4'b0000, 4'b0000, 1'b0);
    ck(90,  4'b0100, 4'b0011, 4'b0000, 1'b0);
    ck(104, 4'b0100, 4'b0011, 4'b0100, 1'b1);
    ck(105, 4'b0100, 4'b0011, 4'b0000, 1'b0);
    wr(106, 4'b0100, 2'd2, 8'd5, 8'd9, 1'b1, 4'b0011, 4'b0000, 1'b0);
    ck(120, 4'b0100, 4'b0011, 4'b0000, 1'b1);
    ck(124, 4'b0100, 4'b0011, 4'b0100, 1'b1);
    ck(125, 4'b0100, 4'b0111, 4'b0000, 1'b0);
    ck(135, 4'b0100, 4'b0111, 4'b0000, 1'b0);
    ck(144, 4'b0100, 4'b0111, 4'b0100, 1'b1);
    wr(146, 4'b0100, 2'd2, 8'd0, 8'd9, 1'b1, 4'b0111, 4'b0000, 1'b0);
    ck(164, 4'b0100, 4'b0111, 4'b0100, 1'b1);
    ck(165, 4'b0100, 4'b0011, 4'b0000, 1'b0);
    ck(184, 4'b0100, 4'b0011, 4'b0000, 1'b1);
    ck(200, 4'b0100, 4'b0011, 4'b0000, 1'b1);
    // write landing on ch0 wrap edge goes straight to active
    ck(202, 4'b0101, 4'b0010, 4'b0000, 1'b0);
    wr(212, 4'b0101, 2'd0, 8'd4, 8'd1, 1'b1, 4'b0011, 4'b0001, 1'b1);
    ck(213, 4'b0101, 4'b0011, 4'b0000, 1'b0);
    ck(217, 4'b0101, 4'b0010, 4'b0000, 1'b0);
    ck(224, 4'b0101, 4'b0010, 4'b0000, 1'b1);
    ck(228, 4'b0101, 4'b0010, 4'b0001, 1'b1);
    ck(229, 4'b0101, 4'b0011, 4'b0000, 1'b0);
    // pending write that reset must discard
    wr(230, 4'b0101, 2'd0, 8'd3, 8'd1, 1'b0, 4'b0011, 4'b0000, 1'b0);

    ch_enable = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pwm_out", 32'(pwm_out), 32'd0);
    chk("reset period_done", 32'(period_done), 32'd0);
    chk("reset tick", 32'(tick), 32'd0);
    release_reset();

    foreach (vq[i]) apply(vq[i]);

    hit_reset("mid-period reset");
    release_reset();
    vq.delete();
    ck(1,  4'b0001, 4'b0001, 4'b0000, 1'b0);
    ck(4,  4'b0001, 4'b0001, 4'b0000, 1'b1);
    ck(8,  4'b0001, 4'b0001, 4'b0000, 1'b1);
    ck(9,  4'b0001, 4'b0000, 4'b0000, 1'b0);
    ck(20, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    ck(21, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    ck(24, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    foreach (vq[i]) apply(vq[i]);

    hit_reset("reset during tick");
    release_reset();
    vq.delete();
    ck(4, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    foreach (vq[i]) apply(vq[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
